noc_vc_input_port: RTL and testbench

//  Parametrised NoC router input port: NUM_VC virtual channels, each buffered in its own VC_DEPTH-entry FIFO.
//  Per-VC XY route computation on head flits and a round-robin switch request toward the switch allocator.

---
 rtl/noc_vc_input_port_if.sv | 33 +++
 rtl/noc_vc_input_port.sv | 160 ++++++++++++++++
 tb/tb_noc_vc_input_port.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_vc_input_port_if.sv
// Link bundle for one router input port: upstream flit/VC in, switch-allocator
// handshake, crossbar flit out, credit return and sticky error flags.
interface noc_vc_input_port_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VC     = 5,
  parameter int VCW        = $clog2(NUM_VC)
);
  logic                  flit_valid_in;
  logic [DATA_WIDTH-1:0] flit_in;
  logic [VCW-1:0]        vc_id_in;
  logic                  sw_req;
  logic [VCW-1:0]        sw_vc;
  logic [2:0]            sw_port;
  logic                  sw_grant;
  logic                  flit_out_valid;
  logic [DATA_WIDTH-1:0] flit_out;
  logic                  credit_valid;
  logic [VCW-1:0]        credit_vc;
  logic                  err_overflow;
  logic                  err_proto;

  modport master (
    output flit_valid_in, flit_in, vc_id_in, sw_grant,
    input  sw_req, sw_vc, sw_port, flit_out_valid, flit_out,
           credit_valid, credit_vc, err_overflow, err_proto
  );

  modport slave (
    input  flit_valid_in, flit_in, vc_id_in, sw_grant,
    output sw_req, sw_vc, sw_port, flit_out_valid, flit_out,
           credit_valid, credit_vc, err_overflow, err_proto
  );
endinterface

// File: rtl/noc_vc_input_port.sv
// NoC router input port: per-VC FIFOs, per-VC XY route FSM, round-robin switch
// request, registered crossbar output and one credit per popped flit.
module noc_vc_input_port #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VC     = 5,
  parameter int VC_DEPTH   = 4,
  parameter int COORD_W    = 3,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0
) (
  input logic                clk,
  input logic                reset,
  noc_vc_input_port_if.slave bus
);
  localparam int VCW = $clog2(NUM_VC);
  localparam int PW  = $clog2(VC_DEPTH);
  localparam int CW  = $clog2(VC_DEPTH + 1);

  localparam logic [2:0] PORT_L = 3'd0;
  localparam logic [2:0] PORT_E = 3'd1;
  localparam logic [2:0] PORT_W = 3'd2;
  localparam logic [2:0] PORT_N = 3'd3;
  localparam logic [2:0] PORT_S = 3'd4;

  typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} vc_state_e;

  function automatic logic [2:0] xy_route(input logic [DATA_WIDTH-1:0] f);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = f[2 +: COORD_W];
    dy = f[2+COORD_W +: COORD_W];
    if (dx > COORD_W'(MY_X)) return PORT_E;
    if (dx < COORD_W'(MY_X)) return PORT_W;
    if (dy > COORD_W'(MY_Y)) return PORT_N;
    if (dy < COORD_W'(MY_Y)) return PORT_S;
    return PORT_L;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(VC_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem    [NUM_VC][VC_DEPTH];
  logic [PW-1:0]         rd_ptr [NUM_VC];
  logic [PW-1:0]         wr_ptr [NUM_VC];
  logic [CW-1:0]         count  [NUM_VC];
  vc_state_e             state  [NUM_VC];
  logic [2:0]            route  [NUM_VC];
  logic [DATA_WIDTH-1:0] head   [NUM_VC];
  logic [VCW-1:0]        rr_ptr;

  logic                  req, grant_pop, disc_hit, disc_pop, pop_any, wr_ok;
  logic [VCW-1:0]        arb_vc, disc_vc, pop_vc;
  logic [NUM_VC-1:0]     wr_hit, pop_hit;

  logic                  vld_p1, credit_vld_p1, err_ovf_q, err_proto_q;
  logic [DATA_WIDTH-1:0] flit_p1;
  logic [VCW-1:0]        credit_vc_p1;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) head[v] = mem[v][rd_ptr[v]];
  end

  // Round-robin search starting at rr_ptr over ACTIVE, non-empty VCs
  always_comb begin
    req    = 1'b0;
    arb_vc = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_VC) idx = idx - NUM_VC;
      if (!req && state[idx] == ACTIVE && count[idx] != '0) begin
        req    = 1'b1;
        arb_vc = VCW'(idx);
      end
    end
  end

  // A switch pop owns the single pop slot; stray-flit discards wait for a free cycle
  always_comb begin
    grant_pop = req && bus.sw_grant;
    disc_hit  = 1'b0;
    disc_vc   = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (!disc_hit && state[v] == IDLE && count[v] != '0 && !head[v][0]) begin
        disc_hit = 1'b1;
        disc_vc  = VCW'(v);
      end
    end
    disc_pop = disc_hit && !grant_pop;
    pop_any  = grant_pop || disc_pop;
    pop_vc   = grant_pop ? arb_vc : disc_vc;
    wr_ok    = 1'b0;
    if (bus.flit_valid_in && int'(bus.vc_id_in) < NUM_VC)
      wr_ok = (count[bus.vc_id_in] != CW'(VC_DEPTH)) || (pop_any && pop_vc == bus.vc_id_in);
    wr_hit  = '0;
    pop_hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit[v]  = wr_ok && (bus.vc_id_in == VCW'(v));
      pop_hit[v] = pop_any && (pop_vc == VCW'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.vc_id_in][wr_ptr[bus.vc_id_in]] <= bus.flit_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v]  <= '0;
        state[v]  <= IDLE;
        route[v]  <= PORT_L;
      end
      rr_ptr        <= '0;
      vld_p1        <= 1'b0;
      flit_p1       <= '0;
      credit_vld_p1 <= 1'b0;
      credit_vc_p1  <= '0;
      err_ovf_q     <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_hit[v])  wr_ptr[v] <= ptr_inc(wr_ptr[v]);
        if (pop_hit[v]) rd_ptr[v] <= ptr_inc(rd_ptr[v]);
        if (wr_hit[v] && !pop_hit[v])      count[v] <= count[v] + CW'(1);
        else if (!wr_hit[v] && pop_hit[v]) count[v] <= count[v] - CW'(1);
        case (state[v])
          IDLE:    if (count[v] != '0 && head[v][0]) state[v] <= ROUTE;
          ROUTE: begin
            route[v] <= xy_route(head[v]);
            state[v] <= ACTIVE;
          end
          ACTIVE:  if (pop_hit[v] && head[v][1]) state[v] <= IDLE;
          default: state[v] <= IDLE;
        endcase
      end
      if (grant_pop) rr_ptr <= (arb_vc == VCW'(NUM_VC - 1)) ? '0 : arb_vc + VCW'(1);
      // p1: popped flit and its credit leave one cycle after the pop
      vld_p1        <= grant_pop;
      if (grant_pop) flit_p1 <= head[arb_vc];
      credit_vld_p1 <= pop_any;
      if (pop_any) credit_vc_p1 <= pop_vc;
      if (bus.flit_valid_in && !wr_ok) err_ovf_q <= 1'b1;
      if (disc_pop) err_proto_q <= 1'b1;
    end
  end

  assign bus.sw_req         = req;
  assign bus.sw_vc          = arb_vc;
  assign bus.sw_port        = route[arb_vc];
  assign bus.flit_out_valid = vld_p1;
  assign bus.flit_out       = flit_p1;
  assign bus.credit_valid   = credit_vld_p1;
  assign bus.credit_vc      = credit_vc_p1;
  assign bus.err_overflow   = err_ovf_q;
  assign bus.err_proto      = err_proto_q;
endmodule

// File: tb/tb_noc_vc_input_port.sv
// Bench for noc_vc_input_port: route table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_noc_vc_input_port;
  localparam int DW = 64, NV = 5, DEPTH = 4, CWD = 3, MX = 1, MY = 1;
  localparam int VCW = $clog2(NV);
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  noc_vc_input_port_if #(.DATA_WIDTH(DW), .NUM_VC(NV)) bus ();

  noc_vc_input_port #(.DATA_WIDTH(DW), .NUM_VC(NV), .VC_DEPTH(DEPTH), .COORD_W(CWD),
                      .MY_X(MX), .MY_Y(MY)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct { int dx; int dy; logic [2:0] port; } route_vec_t;
  route_vec_t tbl [7];

  // reference model state
  logic [DW-1:0]  mq [NV][$];
  int             mph [NV];
  logic [2:0]     mrte [NV];
  int             mrr;
  logic           m_fov, m_cv, m_ovf, m_proto;
  logic [DW-1:0]  m_fo;
  logic [VCW-1:0] m_cvc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int x, input int y, input int tag);
    logic [DW-1:0] f;
    f = '0;
    f[1:0]  = t;
    f[4:2]  = 3'(x);
    f[7:5]  = 3'(y);
    f[39:8] = 32'(tag);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] f, input int vc);
    bus.flit_valid_in = v;
    bus.flit_in       = f;
    bus.vc_id_in      = VCW'(vc);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 0);
    bus.sw_grant = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [1:0] ftype(input logic [DW-1:0] f);
    return f[1:0];
  endfunction

  function automatic logic [2:0] ref_route(input logic [DW-1:0] f);
    int x, y;
    x = int'(f[4:2]);
    y = int'(f[7:5]);
    if (x > MX) return 3'd1;
    if (x < MX) return 3'd2;
    if (y > MY) return 3'd3;
    if (y < MY) return 3'd4;
    return 3'd0;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      mph[v]  = 0;
      mrte[v] = 3'd0;
    end
    mrr = 0; m_fov = 0; m_cv = 0; m_ovf = 0; m_proto = 0; m_fo = '0; m_cvc = '0;
  endtask

  task automatic model_comb(output bit req, output int vc);
    req = 0;
    vc  = 0;
    for (int i = 0; i < NV; i++) begin
      int c;
      c = (mrr + i) % NV;
      if (!req && mph[c] == 2 && mq[c].size() > 0) begin
        req = 1;
        vc  = c;
      end
    end
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] f, input int vcid, input logic g);
    bit req, gp;
    int svc, popvc;
    model_comb(req, svc);
    gp = req && g;
    popvc = gp ? svc : -1;
    if (!gp)
      for (int c = 0; c < NV; c++)
        if (popvc < 0 && mph[c] == 0 && mq[c].size() > 0 &&
            (ftype(mq[c][0]) == T_BODY || ftype(mq[c][0]) == T_TAIL)) popvc = c;
    m_fov = gp;
    if (gp) m_fo = mq[svc][0];
    m_cv = (popvc >= 0);
    if (m_cv) m_cvc = VCW'(popvc);
    if (popvc >= 0 && !gp) m_proto = 1;
    for (int c = 0; c < NV; c++) begin
      if (mph[c] == 0) begin
        if (mq[c].size() > 0 && (ftype(mq[c][0]) == T_HEAD || ftype(mq[c][0]) == T_HT)) mph[c] = 1;
      end else if (mph[c] == 1) begin
        mrte[c] = ref_route(mq[c][0]);
        mph[c]  = 2;
      end else if (c == popvc && (ftype(mq[c][0]) == T_TAIL || ftype(mq[c][0]) == T_HT)) begin
        mph[c] = 0;
      end
    end
    if (popvc >= 0) void'(mq[popvc].pop_front());
    if (gp) mrr = (svc + 1) % NV;
    if (v) begin
      if (vcid >= NV) m_ovf = 1;
      else if (mq[vcid].size() >= DEPTH) m_ovf = 1;
      else mq[vcid].push_back(f);
    end
  endtask

  initial begin
    logic [DW-1:0] f;
    logic [DW-1:0] pkt [4];
    int n, nc;
    int exp_order [3];

    tbl[0] = '{3, 1, 3'd1};
    tbl[1] = '{0, 1, 3'd2};
    tbl[2] = '{1, 3, 3'd3};
    tbl[3] = '{1, 0, 3'd4};
    tbl[4] = '{1, 1, 3'd0};
    tbl[5] = '{7, 0, 3'd1};
    tbl[6] = '{0, 7, 3'd2};
    exp_order = '{0, 1, 4};

    drive(1'b0, '0, 0);
    bus.sw_grant = 1'b0;
    @(negedge clk);
    do_reset();

    chk("rst_sw_req", 64'(bus.sw_req), 64'd0);
    chk("rst_fov", 64'(bus.flit_out_valid), 64'd0);
    chk("rst_flit_out", 64'(bus.flit_out), 64'd0);
    chk("rst_cv", 64'(bus.credit_valid), 64'd0);
    chk("rst_cvc", 64'(bus.credit_vc), 64'd0);
    chk("rst_ovf", 64'(bus.err_overflow), 64'd0);
    chk("rst_proto", 64'(bus.err_proto), 64'd0);

    // single-flit packet latency
    f = mk(T_HT, 3, 1, 100);
    drive(1'b1, f, 2);
    tick();
    drive(1'b0, '0, 0);
    chk("t1_req_e1", 64'(bus.sw_req), 64'd0);
    tick();
    chk("t1_req_e2", 64'(bus.sw_req), 64'd0);
    tick();
    chk("t1_req", 64'(bus.sw_req), 64'd1);
    chk("t1_vc", 64'(bus.sw_vc), 64'd2);
    chk("t1_port", 64'(bus.sw_port), 64'd1);
    bus.sw_grant = 1'b1;
    tick();
    bus.sw_grant = 1'b0;
    chk("t1_fov", 64'(bus.flit_out_valid), 64'd1);
    chk("t1_fo", 64'(bus.flit_out), 64'(f));
    chk("t1_cv", 64'(bus.credit_valid), 64'd1);
    chk("t1_cvc", 64'(bus.credit_vc), 64'd2);
    tick();
    chk("t1_fov_off", 64'(bus.flit_out_valid), 64'd0);
    chk("t1_cv_off", 64'(bus.credit_valid), 64'd0);
    chk("t1_fo_hold", 64'(bus.flit_out), 64'(f));

    // XY route table
    for (int i = 0; i < 7; i++) begin
      f = mk(T_HT, tbl[i].dx, tbl[i].dy, 200 + i);
      drive(1'b1, f, 0);
      tick();
      drive(1'b0, '0, 0);
      tick();
      tick();
      chk($sformatf("tbl%0d_req", i), 64'(bus.sw_req), 64'd1);
      chk($sformatf("tbl%0d_port", i), 64'(bus.sw_port), 64'(tbl[i].port));
      bus.sw_grant = 1'b1;
      tick();
      bus.sw_grant = 1'b0;
      chk($sformatf("tbl%0d_fo", i), 64'(bus.flit_out), 64'(f));
    end

    // 4-flit packet, grant held high
    do_reset();
    pkt[0] = mk(T_HEAD, 1, 0, 300);
    pkt[1] = mk(T_BODY, 1, 0, 301);
    pkt[2] = mk(T_BODY, 1, 0, 302);
    pkt[3] = mk(T_TAIL, 1, 0, 303);
    bus.sw_grant = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 4) drive(1'b1, pkt[cyc], 0);
      else drive(1'b0, '0, 0);
      tick();
      if (bus.sw_req) chk("t2_port", 64'(bus.sw_port), 64'd4);
      if (bus.flit_out_valid) begin
        if (n < 4) chk($sformatf("t2_flit%0d", n), 64'(bus.flit_out), 64'(pkt[n]));
        chk("t2_cvc", 64'(bus.credit_vc), 64'd0);
        n++;
      end
    end
    bus.sw_grant = 1'b0;
    chk("t2_nflits", 64'(n), 64'd4);
    chk("t2_idle_req", 64'(bus.sw_req), 64'd0);

    // reset mid-packet
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(i == 0 ? T_HEAD : T_BODY, 2, 2, 400 + i), 0);
      tick();
    end
    drive(1'b0, '0, 0);
    tick();
    tick();
    chk("t6_pre_req", 64'(bus.sw_req), 64'd1);
    reset = 1'b0;
    bus.sw_grant = 1'b1;
    tick();
    chk("t6_req", 64'(bus.sw_req), 64'd0);
    chk("t6_fov", 64'(bus.flit_out_valid), 64'd0);
    chk("t6_fo", 64'(bus.flit_out), 64'd0);
    chk("t6_cv", 64'(bus.credit_valid), 64'd0);
    chk("t6_cvc", 64'(bus.credit_vc), 64'd0);
    reset = 1'b1;
    nc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.credit_valid || bus.flit_out_valid || bus.sw_req) nc++;
    end
    bus.sw_grant = 1'b0;
    chk("t6_stale", 64'(nc), 64'd0);

    // round-robin order and wrap
    do_reset();
    drive(1'b1, mk(T_HT, 3, 1, 500), 0); tick();
    drive(1'b1, mk(T_HT, 3, 1, 501), 1); tick();
    drive(1'b1, mk(T_HT, 3, 1, 504), 4); tick();
    drive(1'b0, '0, 0);
    tick();
    tick();
    chk("t3_req", 64'(bus.sw_req), 64'd1);
    bus.sw_grant = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t3_fov%0d", k), 64'(bus.flit_out_valid), 64'd1);
      chk($sformatf("t3_order%0d", k), 64'(bus.credit_vc), 64'(exp_order[k]));
    end
    bus.sw_grant = 1'b0;
    chk("t3_drained", 64'(bus.sw_req), 64'd0);
    drive(1'b1, mk(T_HT, 3, 1, 512), 2); tick();
    drive(1'b1, mk(T_HT, 3, 1, 510), 0); tick();
    drive(1'b0, '0, 0);
    tick();
    tick();
    chk("t3_wrap_vc", 64'(bus.sw_vc), 64'd0);
    bus.sw_grant = 1'b1;
    tick();
    chk("t3_wrap_first", 64'(bus.credit_vc), 64'd0);
    tick();
    chk("t3_wrap_second", 64'(bus.credit_vc), 64'd2);
    bus.sw_grant = 1'b0;

    // overflow
    do_reset();
    for (int k = 0; k < 5; k++) begin
      pkt[k % 4] = (k < 4) ? mk(k == 0 ? T_HEAD : T_BODY, 3, 1, 600 + k) : pkt[k % 4];
      drive(1'b1, mk(k == 0 ? T_HEAD : T_BODY, 3, 1, 600 + k), 3);
      tick();
      chk($sformatf("t4_ovf%0d", k), 64'(bus.err_overflow), (k == 4) ? 64'd1 : 64'd0);
    end
    drive(1'b0, '0, 0);
    tick();
    tick();
    tick();
    chk("t4_sticky", 64'(bus.err_overflow), 64'd1);
    chk("t4_vc", 64'(bus.sw_vc), 64'd3);
    bus.sw_grant = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.flit_out_valid) begin
        if (n < 4) chk($sformatf("t4_flit%0d", n), 64'(bus.flit_out), 64'(pkt[n]));
        n++;
      end
    end
    bus.sw_grant = 1'b0;
    chk("t4_nflits", 64'(n), 64'd4);
    chk("t4_sticky2", 64'(bus.err_overflow), 64'd1);
    do_reset();
    chk("t4_cleared", 64'(bus.err_overflow), 64'd0);

    // stray body flit into an idle VC
    drive(1'b1, mk(T_BODY, 3, 1, 700), 1);
    tick();
    drive(1'b0, '0, 0);
    chk("t5_proto_early", 64'(bus.err_proto), 64'd0);
    chk("t5_cv_early", 64'(bus.credit_valid), 64'd0);
    tick();
    chk("t5_proto", 64'(bus.err_proto), 64'd1);
    chk("t5_cv", 64'(bus.credit_valid), 64'd1);
    chk("t5_cvc", 64'(bus.credit_vc), 64'd1);
    chk("t5_fov", 64'(bus.flit_out_valid), 64'd0);
    tick();
    chk("t5_cv_off", 64'(bus.credit_valid), 64'd0);
    chk("t5_req", 64'(bus.sw_req), 64'd0);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r;
      int rv, vc;
      logic v, g;
      model_comb(r, rv);
      chk("rnd_sw_req", 64'(bus.sw_req), 64'(r));
      if (r) begin
        chk("rnd_sw_vc", 64'(bus.sw_vc), 64'(rv));
        chk("rnd_sw_port", 64'(bus.sw_port), 64'(mrte[rv]));
      end
      chk("rnd_fov", 64'(bus.flit_out_valid), 64'(m_fov));
      chk("rnd_fo", 64'(bus.flit_out), 64'(m_fo));
      chk("rnd_cv", 64'(bus.credit_valid), 64'(m_cv));
      chk("rnd_cvc", 64'(bus.credit_vc), 64'(m_cvc));
      chk("rnd_ovf", 64'(bus.err_overflow), 64'(m_ovf));
      chk("rnd_proto", 64'(bus.err_proto), 64'(m_proto));
      v  = ($urandom_range(0, 9) < 6);
      vc = ($urandom_range(0, 15) == 0) ? int'($urandom_range(NV, 7)) : int'($urandom_range(0, NV - 1));
      f  = mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), cyc);
      g  = ($urandom_range(0, 9) < 6);
      drive(v, f, vc);
      bus.sw_grant = g;
      model_step(v, f, vc, g);
      tick();
    end
    drive(1'b0, '0, 0);
    bus.sw_grant = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
